// File: rtl/bcd_to_binary_seq_if.sv
// Request/result handshake bundle for the BCD-to-binary converter.
// master: requester/consumer side; slave: the converter.
interface bcd_to_binary_seq_if #(
  parameter int unsigned BIT = 9
) ();

  logic           in_valid;
  logic           in_ready;
  logic [3:0]     hundreds;
  logic [3:0]     tens;
  logic [3:0]     ones;
  logic           out_valid;
  logic           out_ready;
  logic [BIT-1:0] number;
  logic           err;

  modport master (
    output in_valid, hundreds, tens, ones, out_ready,
    input  in_ready, out_valid, number, err
  );

  modport slave (
    input  in_valid, hundreds, tens, ones, out_ready,
    output in_ready, out_valid, number, err
  );

endinterface

// File: rtl/bcd_to_binary_seq.sv
// Iterative 3-digit BCD-to-binary converter. One digit per cycle, valid/ready
// on both sides. Invalid digits give err=1/number=0; results above 2^BIT-1
// saturate to all ones with err=1.
module bcd_to_binary_seq #(
  parameter int unsigned BIT = 9
) (
  input logic                clk,
  input logic                reset,
  bcd_to_binary_seq_if.slave bus
);

  localparam int unsigned MaxVal = (1 << BIT) - 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     hun_q, hun_d;
  logic [3:0]     ten_q, ten_d;
  logic [3:0]     one_q, one_d;
  logic [9:0]     acc_q, acc_d;
  logic [1:0]     step_q, step_d;
  logic           bad_q, bad_d;
  logic [BIT-1:0] number_q, number_d;
  logic           err_q, err_d;

  logic [3:0]     digit;
  logic [9:0]     acc_step;

  // Digit consumed by the current CONV step: hundreds, tens, then ones.
  always_comb begin
    digit = 4'd0;
    case (step_q)
      2'd0:    digit = hun_q;
      2'd1:    digit = ten_q;
      2'd2:    digit = one_q;
      default: digit = 4'd0;
    endcase
  end

  // acc*10 + digit; max 999 so 10 bits never wrap.
  assign acc_step = (acc_q << 3) + (acc_q << 1) + {6'd0, digit};

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    hun_d    = hun_q;
    ten_d    = ten_q;
    one_d    = one_q;
    acc_d    = acc_q;
    step_d   = step_q;
    bad_d    = bad_q;
    number_d = number_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          hun_d   = bus.hundreds;
          ten_d   = bus.tens;
          one_d   = bus.ones;
          acc_d   = 10'd0;
          step_d  = 2'd0;
          // Flag is captured now; the steps still run so latency is fixed.
          bad_d   = (bus.hundreds > 4'd9) || (bus.tens > 4'd9) || (bus.ones > 4'd9);
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d  = acc_step;
        step_d = step_q + 2'd1;
        if (step_q == 2'd2) begin
          state_d = StDone;
          if (bad_q) begin
            number_d = '0;
            err_d    = 1'b1;
          end else if (32'(acc_step) > MaxVal) begin
            number_d = {BIT{1'b1}};
            err_d    = 1'b1;
          end else begin
            number_d = BIT'(acc_step);
            err_d    = 1'b0;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; an in-flight request is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      hun_q    <= 4'd0;
      ten_q    <= 4'd0;
      one_q    <= 4'd0;
      acc_q    <= 10'd0;
      step_q   <= 2'd0;
      bad_q    <= 1'b0;
      number_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hun_q    <= hun_d;
      ten_q    <= ten_d;
      one_q    <= one_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      bad_q    <= bad_d;
      number_q <= number_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.number    = number_q;
  assign bus.err       = err_q;

endmodule
